can_tx_scheduler: RTL and testbench

CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

---
 rtl/can_tx_scheduler_pkg.sv | 27 ++
 rtl/can_tx_scheduler_arbiter.sv | 40 ++++
 rtl/can_tx_scheduler.sv | 159 +++++++++++++++
 tb/tb_can_tx_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_tx_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// can_sched_pkg
// Shared types and default constants for the CAN transmit scheduler.
//   schedState_t  : scheduler FSM state encoding
//   DEF_*         : default parameter values used by the scheduler modules
//   idxWidth()    : index width helper that never returns zero
// ---------------------------------------------------------------------------
package can_sched_pkg;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_ID_W      = 11;
   localparam int DEF_MAX_RETRY = 8;
   localparam int DEF_TIMEOUT   = 4096;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      ACTIVE  = 2'd2,
      BACKOFF = 2'd3
   } schedState_t;

   // A one-entry vector still needs a one-bit index.
   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/can_tx_scheduler_arbiter.sv
// ---------------------------------------------------------------------------
// can_id_arbiter
// Combinational lowest-identifier selector across the transmit mailboxes.
//   valid    in  NUM_REQ       requesters taking part in this arbitration
//   idVec    in  NUM_REQ*ID_W  packed identifiers, requester i at [i*ID_W +: ID_W]
//   anyValid out 1             at least one requester is valid
//   winIdx   out IDX_W         index of the winner (0 when none valid)
//   winId    out ID_W          identifier of the winner (0 when none valid)
// A lower CAN identifier is a higher bus priority. Ties go to the lowest index
// because the scan runs upward and only a strictly smaller ID replaces the
// current winner.
// ---------------------------------------------------------------------------
module can_id_arbiter
   import can_sched_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_W    = DEF_ID_W,
   parameter int IDX_W   = idxWidth(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]      valid,
   input  logic [NUM_REQ*ID_W-1:0] idVec,
   output logic                    anyValid,
   output logic [IDX_W-1:0]        winIdx,
   output logic [ID_W-1:0]         winId
);

   always_comb begin
      anyValid = 1'b0;
      winIdx   = '0;
      winId    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (valid[i] && (!anyValid || (idVec[i*ID_W +: ID_W] < winId))) begin
            anyValid = 1'b1;
            winIdx   = IDX_W'(i);
            winId    = idVec[i*ID_W +: ID_W];
         end
      end
   end

endmodule

// File: rtl/can_tx_scheduler.sv
// ---------------------------------------------------------------------------
// can_tx_scheduler
// Picks the highest-priority (lowest-ID) pending mailbox when the bus is idle,
// hands it to the CAN tx engine and reports the outcome back to the mailbox.
//
// Ports
//   clk, resetN        clock (posedge) and synchronous active-low reset
//   interframePeriod   bus idle / interframe window open
//   reqValid[NUM_REQ]  per-mailbox pending request
//   reqId[NUM_REQ*ID_W] per-mailbox identifier
//   txDone/txArbLost/txError  tx engine outcome pulses
//   txStart            1-cycle pulse: start frame for txId
//   txId, grantIdx     granted identifier and mailbox index
//   reqDone, reqFail   1-cycle outcome pulses on the granted mailbox bit
//   busy               high while a frame is being started or is in flight
//   stateDbg           current FSM state (schedState_t encoding)
//
// Handshake: a mailbox raises reqValid with a stable reqId and holds it until
// it sees its bit of reqDone or reqFail; dropping it while granted does not
// abort the frame. The tx engine answers a txStart with exactly one of
// txDone/txArbLost/txError (priority done > error > arbLost if several
// coincide); answers outside ACTIVE are ignored. reqDone/reqFail appear the
// cycle after the deciding answer, during BACKOFF.
// ---------------------------------------------------------------------------
module can_tx_scheduler
   import can_sched_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int ID_W      = DEF_ID_W,
   parameter int MAX_RETRY = DEF_MAX_RETRY,
   parameter int TIMEOUT   = DEF_TIMEOUT,
   parameter int IDX_W     = idxWidth(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    interframePeriod,
   input  logic [NUM_REQ-1:0]      reqValid,
   input  logic [NUM_REQ*ID_W-1:0] reqId,
   input  logic                    txDone,
   input  logic                    txArbLost,
   input  logic                    txError,
   output logic                    txStart,
   output logic [ID_W-1:0]         txId,
   output logic [IDX_W-1:0]        grantIdx,
   output logic [NUM_REQ-1:0]      reqDone,
   output logic [NUM_REQ-1:0]      reqFail,
   output logic                    busy,
   output logic [1:0]              stateDbg
);

   localparam int RC_W = $clog2(MAX_RETRY + 1);
   localparam int TO_W = idxWidth(TIMEOUT);

   schedState_t       state, stateNext;
   logic [RC_W-1:0]   retryCnt [NUM_REQ];
   logic [TO_W-1:0]   timeoutCnt;
   logic              maskActive;

   logic [NUM_REQ-1:0] grantOneHot;
   logic [NUM_REQ-1:0] validMasked;
   logic               anyValid;
   logic [IDX_W-1:0]   winIdx;
   logic [ID_W-1:0]    winId;

   logic [RC_W-1:0]    retryCur;
   logic [RC_W-1:0]    retryInc;
   logic               launch;
   logic               doneEvt;
   logic               errEvt;
   logic               arbEvt;
   logic               errExhaust;
   logic               timeoutHit;

   assign grantOneHot = NUM_REQ'(1) << grantIdx;

   // maskActive is high during the IDLE cycle right after BACKOFF, so the
   // mailbox that just finished cannot win again before it has had a cycle
   // to drop or replace its request. grantIdx still names that mailbox.
   assign validMasked = maskActive ? (reqValid & ~grantOneHot) : reqValid;

   can_id_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W),
      .IDX_W   (IDX_W)
   ) u_arbiter (
      .valid    (validMasked),
      .idVec    (reqId),
      .anyValid (anyValid),
      .winIdx   (winIdx),
      .winId    (winId)
   );

   // Next-state and event decode.
   always_comb begin
      retryCur   = retryCnt[grantIdx];
      retryInc   = (retryCur == RC_W'(MAX_RETRY)) ? retryCur : retryCur + RC_W'(1);
      launch     = (state == IDLE) && interframePeriod && anyValid;
      doneEvt    = (state == ACTIVE) && txDone;
      errEvt     = (state == ACTIVE) && !txDone && txError;
      arbEvt     = (state == ACTIVE) && !txDone && !txError && txArbLost;
      timeoutHit = (state == ACTIVE) && !txDone && !txError && !txArbLost &&
                   (timeoutCnt == TO_W'(TIMEOUT - 1));
      errExhaust = errEvt && (retryInc == RC_W'(MAX_RETRY));

      stateNext = state;
      case (state)
         IDLE:    if (launch) stateNext = START;
         START:   stateNext = ACTIVE;
         ACTIVE: begin
            if (doneEvt || errExhaust || timeoutHit) stateNext = BACKOFF;
            else if (errEvt || arbEvt)               stateNext = IDLE;
         end
         BACKOFF: stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state      <= IDLE;
         txId       <= '0;
         grantIdx   <= '0;
         timeoutCnt <= '0;
         maskActive <= 1'b0;
         reqDone    <= '0;
         reqFail    <= '0;
         for (int i = 0; i < NUM_REQ; i++) retryCnt[i] <= '0;
      end else begin
         state      <= stateNext;
         maskActive <= (state == BACKOFF);
         reqDone    <= doneEvt ? grantOneHot : '0;
         reqFail    <= (errExhaust || timeoutHit) ? grantOneHot : '0;

         if (launch) begin
            grantIdx <= winIdx;
            txId     <= winId;
         end

         if (state == START)       timeoutCnt <= '0;
         else if (state == ACTIVE) timeoutCnt <= timeoutCnt + TO_W'(1);

         for (int i = 0; i < NUM_REQ; i++) begin
            if ((state == IDLE) && !reqValid[i]) begin
               retryCnt[i] <= '0;
            end else if (IDX_W'(i) == grantIdx) begin
               if (doneEvt || errExhaust || timeoutHit) retryCnt[i] <= '0;
               else if (errEvt)                         retryCnt[i] <= retryInc;
            end
         end
      end
   end

   always_comb begin
      txStart  = (state == START);
      busy     = (state == START) || (state == ACTIVE);
      stateDbg = state;
   end

endmodule

// File: tb/tb_can_tx_scheduler.sv
module tb_can_tx_scheduler;

   localparam int NUM_REQ   = 4;
   localparam int ID_W      = 11;
   localparam int MAX_RETRY = 8;
   localparam int TIMEOUT   = 4096;
   localparam int IDX_W     = 2;

   // ---------------- clock / reset / signals ----------------
   logic                    clk = 1'b0;
   logic                    resetN = 1'b0;
   logic                    interframePeriod = 1'b0;
   logic [NUM_REQ-1:0]      reqValid = '0;
   logic [NUM_REQ*ID_W-1:0] reqId = '0;
   logic                    txDone = 1'b0;
   logic                    txArbLost = 1'b0;
   logic                    txError = 1'b0;
   logic                    txStart;
   logic [ID_W-1:0]         txId;
   logic [IDX_W-1:0]        grantIdx;
   logic [NUM_REQ-1:0]      reqDone;
   logic [NUM_REQ-1:0]      reqFail;
   logic                    busy;
   logic [1:0]              stateDbg;

   always #5 clk = ~clk;

   can_tx_scheduler #(
      .NUM_REQ   (NUM_REQ),
      .ID_W      (ID_W),
      .MAX_RETRY (MAX_RETRY),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk              (clk),
      .resetN           (resetN),
      .interframePeriod (interframePeriod),
      .reqValid         (reqValid),
      .reqId            (reqId),
      .txDone           (txDone),
      .txArbLost        (txArbLost),
      .txError          (txError),
      .txStart          (txStart),
      .txId             (txId),
      .grantIdx         (grantIdx),
      .reqDone          (reqDone),
      .reqFail          (reqFail),
      .busy             (busy),
      .stateDbg         (stateDbg)
   );

   // ---------------- checking ----------------
   int errCnt = 0;
   int chkCnt = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Phases: 0 waiting for bus, 1 starting, 2 frame in flight, 3 backoff.
   int                 mSt = 0;
   int                 mGrant = 0;
   logic [ID_W-1:0]    mId = '0;
   int                 mRetry [NUM_REQ];
   int                 mTo = 0;
   int                 maskLeft = 0;
   logic [NUM_REQ-1:0] mDone = '0;
   logic [NUM_REQ-1:0] mFail = '0;
   logic [ID_W-1:0]    exp_q[$];

   function automatic logic [ID_W-1:0] idOf(input int i);
      return reqId[i*ID_W +: ID_W];
   endfunction

   task automatic modelStep();
      int best;
      int r;
      bit enterBo;
      best    = -1;
      enterBo = 1'b0;
      mDone   = '0;
      mFail   = '0;
      if (!resetN) begin
         mSt = 0; mGrant = 0; mId = '0; mTo = 0; maskLeft = 0;
         for (int i = 0; i < NUM_REQ; i++) mRetry[i] = 0;
         return;
      end
      case (mSt)
         0: begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (!reqValid[i]) mRetry[i] = 0;
               else if (!(maskLeft > 0 && i == mGrant) && (best < 0 || idOf(i) < idOf(best)))
                  best = i;
            end
            if (interframePeriod && best >= 0) begin
               mGrant = best;
               mId    = idOf(best);
               mSt    = 1;
               exp_q.push_back(mId);
            end
         end
         1: begin mTo = 0; mSt = 2; end
         2: begin
            if (txDone) begin
               mDone[mGrant] = 1'b1; mRetry[mGrant] = 0; mSt = 3; enterBo = 1'b1;
            end else if (txError) begin
               r = mRetry[mGrant] + 1;
               if (r >= MAX_RETRY) begin
                  mFail[mGrant] = 1'b1; mRetry[mGrant] = 0; mSt = 3; enterBo = 1'b1;
               end else begin
                  mRetry[mGrant] = r; mSt = 0;
               end
            end else if (txArbLost) begin
               mSt = 0;
            end else if (mTo >= TIMEOUT - 1) begin
               mFail[mGrant] = 1'b1; mRetry[mGrant] = 0; mSt = 3; enterBo = 1'b1;
            end else begin
               mTo++;
            end
         end
         default: mSt = 0;
      endcase
      if (enterBo)           maskLeft = 2;
      else if (maskLeft > 0) maskLeft--;
   endtask

   task automatic checkOutputs();
      checkVal("txStart", txStart, mSt == 1);
      checkVal("busy", busy, (mSt == 1) || (mSt == 2));
      checkVal("grantIdx", grantIdx, mGrant);
      checkVal("txId", txId, mId);
      checkVal("reqDone", reqDone, mDone);
      checkVal("reqFail", reqFail, mFail);
      if (txStart) begin
         if (exp_q.size() == 0) checkVal("grant_unexpected", 1, 0);
         else                   checkVal("grant_q_id", txId, exp_q.pop_front());
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutputs();
   endtask

   task automatic setId(input int i, input logic [ID_W-1:0] id);
      reqId[i*ID_W +: ID_W] = id;
   endtask

   // Expects IDLE with only mailbox idx pending and a fresh retry count.
   task automatic errorRun(input string tag, input int idx);
      for (int k = 0; k < MAX_RETRY; k++) begin
         cycle();
         checkVal({tag, "_start"}, txStart, 1);
         checkVal({tag, "_gidx"}, grantIdx, idx);
         cycle();
         txError = 1'b1;
         cycle();
         txError = 1'b0;
         checkVal({tag, "_fail"}, reqFail, (k == MAX_RETRY - 1) ? (32'd1 << idx) : 32'd0);
      end
   endtask

   function automatic logic [ID_W-1:0] randId();
      return ($urandom_range(0, 3) == 0) ? ID_W'($urandom_range(0, 2047)) : ID_W'($urandom_range(0, 15));
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      for (int i = 0; i < NUM_REQ; i++) mRetry[i] = 0;

      // Reset state
      resetN = 1'b0;
      cycle();
      cycle();
      checkVal("rst_busy", busy, 0);
      checkVal("rst_txStart", txStart, 0);
      checkVal("rst_txId", txId, 0);
      checkVal("rst_grantIdx", grantIdx, 0);
      resetN = 1'b1;
      cycle();

      // Lowest ID wins, tie goes to the lower index
      setId(0, 11'h3FF); setId(1, 11'h120); setId(2, 11'h050); setId(3, 11'h050);
      reqValid = 4'b1110;
      interframePeriod = 1'b1;
      cycle();
      checkVal("t39_start", txStart, 1);
      checkVal("t39_gidx", grantIdx, 2);
      checkVal("t39_id", txId, 11'h050);
      cycle();
      checkVal("t39_pulse_len", txStart, 0);
      txDone = 1'b1;
      cycle();
      txDone = 1'b0;
      checkVal("t39_done", reqDone, 4'b0100);
      reqValid = 4'b0000;
      cycle();
      cycle();

      // Seven errors retry, the eighth fails
      setId(0, 11'h300);
      reqValid = 4'b0001;
      errorRun("t40", 0);
      checkVal("t40_backoff_busy", busy, 0);
      reqValid = 4'b0000;
      cycle();
      checkVal("t40_idle_start", txStart, 0);

      // Arbitration loss re-arbitrates; loser's retry count stays clear
      setId(1, 11'h200);
      reqValid = 4'b0010;
      cycle();
      checkVal("t41_gidx1", grantIdx, 1);
      cycle();
      setId(0, 11'h010);
      reqValid = 4'b0011;
      txArbLost = 1'b1;
      cycle();
      txArbLost = 1'b0;
      cycle();
      checkVal("t41_start", txStart, 1);
      checkVal("t41_gidx0", grantIdx, 0);
      checkVal("t41_id", txId, 11'h010);
      cycle();
      txDone = 1'b1;
      cycle();
      txDone = 1'b0;
      checkVal("t41_done0", reqDone, 4'b0001);
      reqValid = 4'b0010;
      cycle();
      errorRun("t41_retry1", 1);
      reqValid = 4'b0000;
      cycle();

      // Done and error together: done wins
      setId(2, 11'h0AA);
      reqValid = 4'b0100;
      cycle();
      cycle();
      txDone = 1'b1; txError = 1'b1;
      cycle();
      txDone = 1'b0; txError = 1'b0;
      checkVal("t42_done", reqDone, 4'b0100);
      checkVal("t42_nofail", reqFail, 0);
      reqValid = 4'b0000;
      cycle();

      // Timeout with no response
      setId(3, 11'h7FF);
      reqValid = 4'b1000;
      cycle();
      cycle();
      n = 0;
      do begin
         cycle();
         n++;
      end while (reqFail == 0 && n < 5000);
      checkVal("t43_to_cycles", n, TIMEOUT);
      checkVal("t43_to_fail", reqFail, 4'b1000);
      reqValid = 4'b0000;
      cycle();

      // Reset in the middle of a frame
      setId(0, 11'h001);
      reqValid = 4'b0001;
      cycle();
      cycle();
      cycle();
      resetN = 1'b0;
      txDone = 1'b1;
      cycle();
      checkVal("t43r_busy", busy, 0);
      checkVal("t43r_done", reqDone, 0);
      checkVal("t43r_fail", reqFail, 0);
      checkVal("t43r_txId", txId, 0);
      checkVal("t43r_gidx", grantIdx, 0);
      resetN = 1'b1;
      txDone = 1'b0;
      reqValid = 4'b0000;
      cycle();
      checkVal("t43r_nopulse", reqDone | reqFail, 0);

      // Bus closed holds requests; stray txDone in IDLE is ignored
      interframePeriod = 1'b0;
      setId(0, 11'h123);
      reqValid = 4'b0001;
      txDone = 1'b1;
      cycle();
      txDone = 1'b0;
      checkVal("t44_stray_done", reqDone, 0);
      for (int k = 0; k < 4; k++) begin
         cycle();
         checkVal("t44_hold", txStart, 0);
      end
      interframePeriod = 1'b1;
      cycle();
      checkVal("t44_start", txStart, 1);
      cycle();
      txDone = 1'b1;
      cycle();
      txDone = 1'b0;
      reqValid = 4'b0000;
      cycle();

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (mDone[i] || mFail[i]) begin
               if ($urandom_range(0, 1) == 0) reqValid[i] = 1'b0;
               else                           setId(i, randId());
            end else if (!reqValid[i] && $urandom_range(0, 7) == 0) begin
               setId(i, randId());
               reqValid[i] = 1'b1;
            end
         end
         interframePeriod = ($urandom_range(0, 3) != 0);
         if (mSt == 2) begin
            txDone    = ($urandom_range(0, 9) == 0);
            txError   = ($urandom_range(0, 4) == 0);
            txArbLost = ($urandom_range(0, 6) == 0);
         end else begin
            txDone    = ($urandom_range(0, 19) == 0);
            txError   = ($urandom_range(0, 19) == 0);
            txArbLost = ($urandom_range(0, 19) == 0);
         end
         resetN = ($urandom_range(0, 499) != 0);
         cycle();
      end

      resetN = 1'b1;
      txDone = 1'b0; txError = 1'b0; txArbLost = 1'b0;
      reqValid = '0;
      cycle();
      cycle();
      checkVal("grant_q_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule
